display_fifo: RTL and testbench
===============================

Name: display_fifo

Overview:
- Synchronous FIFO buffer directly upstream of the 7-seg hex decoder stage.
- Accepts DATA_WIDTH-bit words on write pulses and presents the most recently read word on out_data.
- out_valid drives the decoder's display-enable input, so the display stays blank until the first read.
- Write and read pulses are already single-cycle, i.e. debounced and edge-detected upstream.

Parameters:
- DATA_WIDTH, 4, width of each stored word; matches the hex decoder data input.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8 by default).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request, one word per cycle while high.
- wr_data  input  DATA_WIDTH  word to write.
- rd_en  input  1  read request, one word per cycle while high.
- out_data  output  DATA_WIDTH  last word read; feeds the decoder data input.
- out_valid  output  1  high once any word has been read; feeds the decoder enable.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- count  output  ADDR_WIDTH+1  number of stored words, 0..depth.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk. Reset has priority over all requests.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0.
  - out_data = 0, out_valid = 0.
  - Storage contents are undefined and never observable.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
  - An accepted write stores wr_data at mem[wr_ptr].
  - wr_ptr increments modulo depth (natural wrap of ADDR_WIDTH bits).
- Read acceptance: rd_acc = rd_en & ~empty.
  - out_data <= mem[rd_ptr] on the next posedge, giving 1-cycle latency from rd_en to out_data.
  - rd_ptr increments modulo depth.
  - out_valid <= 1 and stays 1 until reset.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- full and empty are combinational decodes of registered count, so they are glitch-free relative to clk.
- Boundary conditions:
  - Write when full with no read: ignored; storage, pointers and count unchanged.
  - Read when empty: ignored; out_data and out_valid hold.
  - Simultaneous read and write when full: both accepted; the oldest word moves to out_data, the new word is stored, count stays at depth.
  - Simultaneous read and write when empty: write accepted, read ignored; count becomes 1.
  - Simultaneous read and write otherwise: both accepted, count unchanged.
  - Pointer wrap: after 8 writes and 8 reads, both pointers return to 0; ordering is preserved across wrap.
- Reset mid-operation: all stored words are discarded and out_valid drops to 0 the next cycle, so the display blanks.

Optional Feature:
- Macro: DISPLAY_FIFO_ERR_FLAGS_EN.
- When defined: adds outputs overflow and underflow, each 1 bit.
  - overflow is set on any cycle with wr_en & ~wr_acc.
  - underflow is set on any cycle with rd_en & empty.
  - Both are sticky until reset; reset value is 0.
- When undefined: neither port exists, and dropped requests are silently ignored.

Decomposition:
- Package display_fifo_pkg holds:
  - localparam defaults DATA_WIDTH_DEF = 4 and ADDR_WIDTH_DEF = 3.
  - typedef data_t (logic [DATA_WIDTH_DEF-1:0]).
  - typedef ptr_t (logic [ADDR_WIDTH_DEF-1:0]).
  - typedef cnt_t (logic [ADDR_WIDTH_DEF:0]).
- One natural sub-module, fifo_ctrl, owns:
  - pointers, count, full/empty;
  - wr_acc/rd_acc generation;
  - the optional error flags.
- The top level holds the storage array and the out_data/out_valid registers.

Test Plan:
- Reset, then idle 3 cycles -> out_valid = 0, empty = 1, full = 0, count = 0, out_data = 0.
- Write 4'h3, then 4'hA; read once -> the cycle after the read, out_data = 4'h3, out_valid = 1, count = 1; read again -> out_data = 4'hA, empty = 1.
- Write 0..7, then write 4'hF -> full = 1, count = 8, 4'hF dropped (overflow = 1 with macro); eight reads -> out_data sequence 0..7, never F.
- When full, assert wr_en with 4'hC and rd_en together -> out_data = 0, count stays 8; later reads yield 1..7 then C.
- Empty FIFO, assert rd_en -> out_data and out_valid unchanged (underflow = 1 with macro); simultaneous wr 4'h5 + rd -> count = 1, next read gives 4'h5.
- Fill 5 words, pulse reset mid-stream -> next cycle count = 0, empty = 1, out_valid = 0; 12 write/read pairs afterwards across pointer wrap preserve order.

Source files
------------

// File: rtl/display_fifo_pkg.sv
// Shared defaults and types for the display FIFO feeding the 7-seg hex decoder.
package display_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
  typedef logic [ADDR_WIDTH_DEF:0]   cnt_t;

endpackage

// File: rtl/display_fifo_ctrl.sv
// Pointer/occupancy controller for display_fifo; optional sticky error flags
// are built when DISPLAY_FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl
  import display_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  wr_acc,
  output logic                  rd_acc,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  // full/empty decode the registered count, so they only move on clk edges.
  assign full   = (count_q == CNT_DEPTH);
  assign empty  = (count_q == CNT_ZERO);
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & ~wr_acc);
    underflow_d = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: rtl/display_fifo.sv
// Synchronous FIFO ahead of the hex decoder; out_valid blanks the display until
// the first read. Optional overflow/underflow ports: DISPLAY_FIFO_ERR_FLAGS_EN.
module display_fifo
  import display_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  full,
  output logic                  empty,
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .full      (full),
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  // Storage is never reset; its contents are only visible through accepted reads.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (rd_acc) begin
      out_data_d  = mem_q[rd_ptr];
      out_valid_d = 1'b1;
    end else begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_display_fifo.sv
// Directed self-checking bench for display_fifo (default 4-bit x 8 configuration).
module tb_display_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] out_data;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_tests;
  int n_fail;

  display_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read();
    rd_en = 1'b1; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_both(input logic [3:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 4'h0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
`endif
  endtask

  task automatic test_basic();
    do_write(4'h3);
    do_write(4'hA);
    n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count2 got %0d want 2", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_blank got %b want 0", out_valid); end
    do_read();
    n_tests++; if (out_data !== 4'h3) begin n_fail++; $display("FAIL basic_rd1 got %h want 3", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1 got %0d want 1", count); end
    do_read();
    n_tests++; if (out_data !== 4'hA) begin n_fail++; $display("FAIL basic_rd2 got %h want a", out_data); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) do_write(4'(i));
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
    do_write(4'hF);
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count_after got %0d want 8", count); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_after got %b want 1", full); end
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
`endif
    for (int i = 0; i < 8; i++) begin
      do_read();
      n_tests++; if (out_data !== 4'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h want %h", i, out_data, 4'(i)); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %b want 1", empty); end
  endtask

  task automatic test_full_rw();
    logic [3:0] exp_seq [8];
    for (int i = 0; i < 7; i++) exp_seq[i] = 4'(i + 1);
    exp_seq[7] = 4'hC;
    for (int i = 0; i < 8; i++) do_write(4'(i));
    do_both(4'hC);
    n_tests++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL fullrw_out got %h want 0", out_data); end
    n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL fullrw_count got %0d want 8", count); end
    for (int i = 0; i < 8; i++) begin
      do_read();
      n_tests++; if (out_data !== exp_seq[i]) begin n_fail++; $display("FAIL fullrw_order[%0d] got %h want %h", i, out_data, exp_seq[i]); end
    end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL fullrw_drained got %0d want 0", count); end
  endtask

  task automatic test_underflow();
    do_read();
    n_tests++; if (out_data !== 4'hC) begin n_fail++; $display("FAIL udf_hold_data got %h want c", out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL udf_hold_valid got %b want 1", out_valid); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL udf_count got %0d want 0", count); end
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag got %b want 1", underflow); end
`endif
    do_both(4'h5);
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL udf_rw_count got %0d want 1", count); end
    n_tests++; if (out_data !== 4'hC) begin n_fail++; $display("FAIL udf_rw_data got %h want c", out_data); end
    do_read();
    n_tests++; if (out_data !== 4'h5) begin n_fail++; $display("FAIL udf_next got %h want 5", out_data); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    for (int i = 0; i < 5; i++) do_write(4'(i + 9));
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", empty); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
`ifdef DISPLAY_FIFO_ERR_FLAGS_EN
    n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL mid_flags got %b want 00", {overflow, underflow}); end
`endif
    for (int i = 0; i < 12; i++) begin
      d = 4'((i * 3 + 1) % 16);
      do_write(d);
      do_read();
      n_tests++; if (out_data !== d) begin n_fail++; $display("FAIL wrap_order[%0d] got %h want %h", i, out_data, d); end
    end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", count); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", out_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 4'h0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
